ipsl_hmic_h_ddrphy_update_exec_v1_1: RTL

Executes PHY-initiated update requests issued by the DDR PHY update controller. On each `update_start` it performs the DFI PHY-update handshake with the memory controller. It then runs either a DLL re-lock pulse sequence or a saturating DQS-gate tap adjustment per byte lane. It returns a one-cycle `ddrphy_update_done` to the update controller and drives the PHY tap-load strobes.

---
 rtl/ipsl_hmic_h_ddrphy_update_exec_v1_1.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ipsl_hmic_h_ddrphy_update_exec_v1_1.sv
// DDR PHY update executor: DFI PHY-update handshake followed by either a DLL
// re-lock pulse or a saturating per-lane DQS-gate tap adjustment.
module ipsl_hmic_h_ddrphy_update_exec_v1_1 #(
  parameter string DATA_WIDTH    = "16BIT",
  parameter int    DLL_UPD_PULSE = 8,
  parameter int    DLL_SETTLE    = 32,
  parameter int    ACK_TIMEOUT   = 1023
) (
  input  logic       rclk,
  input  logic       rst_n,
  input  logic       update_start,
  input  logic [1:0] ddrphy_update_type,
  input  logic [1:0] ddrphy_update_comp_val_l,
  input  logic [1:0] ddrphy_update_comp_val_h,
  input  logic       ddrphy_update_comp_dir_l,
  input  logic       ddrphy_update_comp_dir_h,
  output logic       ddrphy_update_done,
  output logic       dfi_phyupd_req,
  input  logic       dfi_phyupd_ack,
  output logic       dll_update_n,
  input  logic       gate_train_done,
  input  logic [4:0] gate_init_l,
  input  logic [4:0] gate_init_h,
  output logic [4:0] dqs_gate_l,
  output logic [4:0] dqs_gate_h,
  output logic       gate_load,
  output logic       upd_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DLL_PULSE,
    S_DLL_SETTLE,
    S_GATE_ADJ,
    S_GATE_LOAD,
    S_DONE
  } state_t;

  localparam logic        HIGH_LANE_EN = (DATA_WIDTH == "16BIT");
  localparam logic [15:0] PULSE_LAST   = 16'(DLL_UPD_PULSE - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(DLL_SETTLE - 1);
  localparam logic [15:0] ACK_LIMIT    = 16'(ACK_TIMEOUT);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_start_d;
  logic        r_type_gate;
  logic [1:0]  r_val_l;
  logic [1:0]  r_val_h;
  logic        r_dir_l;
  logic        r_dir_h;
  logic [15:0] r_timer;
  logic [15:0] r_cnt;
  logic [4:0]  r_gate_l;
  logic [4:0]  r_gate_h;
  logic        r_timeout_err;

  logic        w_trigger;
  logic [15:0] w_timer_inc;
  logic [15:0] w_timer_next;
  logic [15:0] w_cnt_next;
  logic        w_set_err;

  // Saturating tap step: clamps to 0..31 instead of wrapping.
  function automatic logic [4:0] satAdj(input logic [4:0] cur, input logic [1:0] val,
                                        input logic dir);
    logic [5:0] sum;
    if (dir) begin
      sum = {1'b0, cur} + {4'b0000, val};
      satAdj = sum[5] ? 5'd31 : sum[4:0];
    end else begin
      satAdj = ({3'b000, val} > cur) ? 5'd0 : (cur - {3'b000, val});
    end
  endfunction

  assign w_trigger   = update_start & ~r_start_d & gate_train_done;
  assign w_timer_inc = r_timer + 16'd1;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_start_d     <= 1'b0;
      r_timer       <= 16'd0;
      r_cnt         <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_start_d <= update_start;
      r_timer   <= w_timer_next;
      r_cnt     <= w_cnt_next;
      if (w_set_err) r_timeout_err <= 1'b1;
    end
  end

  // Request parameters are frozen at the trigger so later input changes are ignored.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_type_gate <= 1'b0;
      r_val_l     <= 2'd0;
      r_val_h     <= 2'd0;
      r_dir_l     <= 1'b0;
      r_dir_h     <= 1'b0;
    end else if (r_state == S_IDLE && w_trigger) begin
      r_type_gate <= ddrphy_update_type[0];
      r_val_l     <= ddrphy_update_comp_val_l;
      r_val_h     <= ddrphy_update_comp_val_h;
      r_dir_l     <= ddrphy_update_comp_dir_l;
      r_dir_h     <= ddrphy_update_comp_dir_h;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_l <= 5'd0;
      r_gate_h <= 5'd0;
    end else if (!gate_train_done) begin
      r_gate_l <= gate_init_l;
      r_gate_h <= gate_init_h;
    end else if (r_state == S_GATE_ADJ) begin
      r_gate_l <= satAdj(r_gate_l, r_val_l, r_dir_l);
      if (HIGH_LANE_EN) r_gate_h <= satAdj(r_gate_h, r_val_h, r_dir_h);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_timer_next = r_timer;
    w_cnt_next   = r_cnt;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_next = 16'd0;
        w_cnt_next   = 16'd0;
        if (w_trigger) w_next_state = ddrphy_update_type[1] ? S_DONE : S_REQ;
      end
      S_REQ: begin
        // An ack arriving on the timeout cycle still wins.
        if (dfi_phyupd_ack) begin
          w_next_state = r_type_gate ? S_GATE_ADJ : S_DLL_PULSE;
          w_timer_next = 16'd0;
        end else if (w_timer_inc == ACK_LIMIT) begin
          w_next_state = S_DONE;
          w_timer_next = 16'd0;
          w_set_err    = 1'b1;
        end else begin
          w_timer_next = w_timer_inc;
        end
      end
      S_DLL_PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_next_state = S_DLL_SETTLE;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_DLL_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_next_state = S_DONE;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_GATE_ADJ:  w_next_state = S_GATE_LOAD;
      S_GATE_LOAD: w_next_state = S_DONE;
      S_DONE: begin
        w_next_state = S_IDLE;
        w_timer_next = 16'd0;
        w_cnt_next   = 16'd0;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign ddrphy_update_done = (r_state == S_DONE);
  assign gate_load          = (r_state == S_GATE_LOAD);
  assign dll_update_n       = (r_state != S_DLL_PULSE);
  assign dfi_phyupd_req     = (r_state == S_REQ) || (r_state == S_DLL_PULSE) ||
                              (r_state == S_DLL_SETTLE) || (r_state == S_GATE_ADJ) ||
                              (r_state == S_GATE_LOAD);
  assign dqs_gate_l         = r_gate_l;
  assign dqs_gate_h         = r_gate_h;
  assign upd_timeout_err    = r_timeout_err;

endmodule
